// File: rtl/actuator_pkg.sv
// Shared types and defaults for the actuator phase sequencer.
package actuator_pkg;

  localparam int NUM_CELLS = 16;
  localparam int CCR_WIDTH = 32;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_SETUP  = 3'd1,
    PH_ON     = 3'd2,
    PH_DEAD   = 3'd3,
    PH_RETURN = 3'd4
  } phase_t;

  // First phase after cur with a nonzero duration; PH_IDLE means end-of-cycle.
  function automatic phase_t next_active(input phase_t cur,
                                         input logic [CCR_WIDTH-1:0] c1,
                                         input logic [CCR_WIDTH-1:0] c2,
                                         input logic [CCR_WIDTH-1:0] c3);
    next_active = PH_IDLE;
    case (cur)
      PH_SETUP: begin
        if (c1 != '0)      next_active = PH_ON;
        else if (c2 != '0) next_active = PH_DEAD;
        else if (c3 != '0) next_active = PH_RETURN;
      end
      PH_ON: begin
        if (c2 != '0)      next_active = PH_DEAD;
        else if (c3 != '0) next_active = PH_RETURN;
      end
      PH_DEAD: begin
        if (c3 != '0)      next_active = PH_RETURN;
      end
      default: next_active = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/actuator_phase_sequencer_if.sv
// Control/config inputs and pad-drive outputs of the actuator phase sequencer.
interface actuator_phase_sequencer_if #(
  parameter int NUM_CELLS = actuator_pkg::NUM_CELLS,
  parameter int CCR_WIDTH = actuator_pkg::CCR_WIDTH
) ();
  logic                 enable;
  logic                 abort;
  logic [NUM_CELLS-1:0] cell_state;
  logic [CCR_WIDTH-1:0] ccr0;
  logic [CCR_WIDTH-1:0] ccr1;
  logic [CCR_WIDTH-1:0] ccr2;
  logic [CCR_WIDTH-1:0] ccr3;
  logic [NUM_CELLS-1:0] drive_p;
  logic [NUM_CELLS-1:0] drive_n;
  logic [2:0]           phase;
  logic                 busy;
  logic                 cycle_done;

  modport master (
    output enable, abort, cell_state, ccr0, ccr1, ccr2, ccr3,
    input  drive_p, drive_n, phase, busy, cycle_done
  );

  modport slave (
    input  enable, abort, cell_state, ccr0, ccr1, ccr2, ccr3,
    output drive_p, drive_n, phase, busy, cycle_done
  );
endinterface

// File: rtl/actuator_phase_sequencer_phase_timer.sv
// Phase duration down-counter; expired is registered and high while the count is zero.
module phase_timer
  import actuator_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [CCR_WIDTH-1:0] load_value,
  output logic                 expired
);

  logic [CCR_WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count   <= '0;
      expired <= 1'b1;
    end else if (load) begin
      count   <= load_value;
      expired <= (load_value == '0);
    end else if (count != '0) begin
      count   <= count - 1'b1;
      expired <= (count == {{(CCR_WIDTH-1){1'b0}}, 1'b1});
    end
  end

endmodule

// File: rtl/actuator_phase_sequencer.sv
// Four-phase actuation sequencer driving differential per-cell pads.
//   state     | meaning
//   PH_IDLE   | waiting for enable, pads off
//   PH_SETUP  | pre-drive settle, ccr0 cycles (min 1)
//   PH_ON     | drive_p = latched mask, ccr1 cycles
//   PH_DEAD   | both pads off, ccr2 cycles
//   PH_RETURN | drive_n = latched mask, ccr3 cycles
module actuator_phase_sequencer
  import actuator_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  actuator_phase_sequencer_if.slave bus
);

  phase_t               state_q, state_d, nxt;
  logic [NUM_CELLS-1:0] mask_q;
  logic                 mask_load;
  logic                 cycle_end;
  logic                 tmr_load;
  logic [CCR_WIDTH-1:0] tmr_value;
  logic                 tmr_expired;

  phase_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (bus.abort),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    nxt       = PH_IDLE;
    mask_load = 1'b0;
    cycle_end = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;

    if (state_q == PH_IDLE) begin
      if (bus.enable) begin
        state_d   = PH_SETUP;
        mask_load = 1'b1;
      end
    end else if (tmr_expired) begin
      nxt = next_active(state_q, bus.ccr1, bus.ccr2, bus.ccr3);
      if (nxt != PH_IDLE) begin
        state_d = nxt;
      end else begin
        cycle_end = 1'b1;
        if (bus.enable) begin
          state_d   = PH_SETUP;
          mask_load = 1'b1;
        end else begin
          state_d = PH_IDLE;
        end
      end
    end

    // Every phase entry (including SETUP re-entry) reloads the timer.
    tmr_load = (state_d != PH_IDLE) && (mask_load || (state_q != PH_IDLE && tmr_expired));
    case (state_d)
      PH_SETUP:  tmr_value = (bus.ccr0 == '0) ? '0 : bus.ccr0 - 1'b1;
      PH_ON:     tmr_value = bus.ccr1 - 1'b1;
      PH_DEAD:   tmr_value = bus.ccr2 - 1'b1;
      PH_RETURN: tmr_value = bus.ccr3 - 1'b1;
      default:   tmr_value = '0;
    endcase

    if (bus.abort) begin
      state_d   = PH_IDLE;
      mask_load = 1'b0;
      cycle_end = 1'b0;
      tmr_load  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= PH_IDLE;
      mask_q         <= '0;
      bus.drive_p    <= '0;
      bus.drive_n    <= '0;
      bus.phase      <= PH_IDLE;
      bus.busy       <= 1'b0;
      bus.cycle_done <= 1'b0;
    end else begin
      state_q        <= state_d;
      if (mask_load) mask_q <= bus.cell_state;
      bus.drive_p    <= (state_d == PH_ON)     ? mask_q : '0;
      bus.drive_n    <= (state_d == PH_RETURN) ? mask_q : '0;
      bus.phase      <= state_d;
      bus.busy       <= (state_d != PH_IDLE);
      bus.cycle_done <= cycle_end;
    end
  end

endmodule

// File: tb/tb_actuator_phase_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor checks them.
module tb_actuator_phase_sequencer;
  import actuator_pkg::*;

  logic clock = 1'b0;
  logic reset;

  actuator_phase_sequencer_if bus ();

  actuator_phase_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [2:0]  ph;
    logic [15:0] dp;
    logic [15:0] dn;
    logic        busy;
    logic        cd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expect phase ph for n cycles starting after edge 'at'; cd_first sets cycle_done on the first.
  task automatic expect_run(input int at, input phase_t ph, input int n,
                            input logic [15:0] mask, input logic cd_first);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.at   = at + i;
      e.ph   = ph;
      e.dp   = (ph == PH_ON)     ? mask : 16'h0000;
      e.dn   = (ph == PH_RETURN) ? mask : 16'h0000;
      e.busy = (ph != PH_IDLE);
      e.cd   = (i == 0) ? cd_first : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL stale_expect: expected entry for cycle %0d never checked (now %0d)", sb[0].at, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].at == cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if ({bus.phase, bus.drive_p, bus.drive_n, bus.busy, bus.cycle_done} !==
          {mon_e.ph, mon_e.dp, mon_e.dn, mon_e.busy, mon_e.cd}) begin
        n_fail++;
        $display("FAIL cycle_%0d: got phase=%0d dp=%h dn=%h busy=%b cd=%b, want phase=%0d dp=%h dn=%h busy=%b cd=%b",
                 cyc, bus.phase, bus.drive_p, bus.drive_n, bus.busy, bus.cycle_done,
                 mon_e.ph, mon_e.dp, mon_e.dn, mon_e.busy, mon_e.cd);
      end
    end
    if (cyc > 0) begin
      n_checks++;
      if ((bus.drive_p & bus.drive_n) !== 16'h0000) begin
        n_fail++;
        $display("FAIL drive_overlap cycle_%0d: dp&dn=%h, want 0000", cyc, bus.drive_p & bus.drive_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.abort      = 1'b0;
    bus.cell_state = '0;
    bus.ccr0 = '0; bus.ccr1 = '0; bus.ccr2 = '0; bus.ccr3 = '0;

    // Reset state
    expect_run(1, PH_IDLE, 5, 16'h0000, 1'b0);
    step(3);
    reset = 1'b0;
    step(2);

    // 2,3,1,2 with enable held: back-to-back cycles, then enable drop mid-ON of loop 2
    c = cyc;
    bus.ccr0 = 2; bus.ccr1 = 3; bus.ccr2 = 1; bus.ccr3 = 2;
    bus.cell_state = 16'h00A5;
    bus.enable = 1'b1;
    expect_run(c+1,  PH_SETUP,  2, 16'h00A5, 1'b0);
    expect_run(c+3,  PH_ON,     3, 16'h00A5, 1'b0);
    expect_run(c+6,  PH_DEAD,   1, 16'h00A5, 1'b0);
    expect_run(c+7,  PH_RETURN, 2, 16'h00A5, 1'b0);
    expect_run(c+9,  PH_SETUP,  2, 16'h00A5, 1'b1);
    expect_run(c+11, PH_ON,     3, 16'h00A5, 1'b0);
    expect_run(c+14, PH_DEAD,   1, 16'h00A5, 1'b0);
    expect_run(c+15, PH_RETURN, 2, 16'h00A5, 1'b0);
    expect_run(c+17, PH_IDLE,   2, 16'h0000, 1'b1);
    step(12);
    bus.enable = 1'b0;
    step(7);

    // enable dropped during ON; mid-cycle ccr1/cell_state writes ignored
    c = cyc;
    bus.ccr0 = 1; bus.ccr1 = 5; bus.ccr2 = 1; bus.ccr3 = 1;
    bus.cell_state = 16'h0F0F;
    bus.enable = 1'b1;
    expect_run(c+1, PH_SETUP,  1, 16'h0F0F, 1'b0);
    expect_run(c+2, PH_ON,     5, 16'h0F0F, 1'b0);
    expect_run(c+7, PH_DEAD,   1, 16'h0F0F, 1'b0);
    expect_run(c+8, PH_RETURN, 1, 16'h0F0F, 1'b0);
    expect_run(c+9, PH_IDLE,   2, 16'h0000, 1'b1);
    step(3);
    bus.enable = 1'b0;
    bus.ccr1 = 9;
    bus.cell_state = 16'hFFFF;
    step(8);

    // ON and DEAD skipped: SETUP(1) -> RETURN(4)
    c = cyc;
    bus.ccr0 = 1; bus.ccr1 = 0; bus.ccr2 = 0; bus.ccr3 = 4;
    bus.cell_state = 16'h1234;
    bus.enable = 1'b1;
    expect_run(c+1,  PH_SETUP,  1, 16'h1234, 1'b0);
    expect_run(c+2,  PH_RETURN, 4, 16'h1234, 1'b0);
    expect_run(c+6,  PH_SETUP,  1, 16'h1234, 1'b1);
    expect_run(c+7,  PH_RETURN, 4, 16'h1234, 1'b0);
    expect_run(c+11, PH_IDLE,   2, 16'h0000, 1'b1);
    step(7);
    bus.enable = 1'b0;
    step(6);

    // All-zero durations: one SETUP cycle per loop, cycle_done every cycle
    c = cyc;
    bus.ccr0 = 0; bus.ccr1 = 0; bus.ccr2 = 0; bus.ccr3 = 0;
    bus.cell_state = 16'h00FF;
    bus.enable = 1'b1;
    expect_run(c+1, PH_SETUP, 1, 16'h00FF, 1'b0);
    for (int k = 2; k <= 4; k++) expect_run(c+k, PH_SETUP, 1, 16'h00FF, 1'b1);
    expect_run(c+5, PH_IDLE, 1, 16'h0000, 1'b1);
    expect_run(c+6, PH_IDLE, 1, 16'h0000, 1'b0);
    step(4);
    bus.enable = 1'b0;
    step(3);

    // abort in the 2nd ON cycle, restart one clock after abort falls
    c = cyc;
    bus.ccr0 = 1; bus.ccr1 = 3; bus.ccr2 = 1; bus.ccr3 = 1;
    bus.cell_state = 16'h00A5;
    bus.enable = 1'b1;
    expect_run(c+1,  PH_SETUP,  1, 16'h00A5, 1'b0);
    expect_run(c+2,  PH_ON,     2, 16'h00A5, 1'b0);
    expect_run(c+4,  PH_IDLE,   1, 16'h0000, 1'b0);
    expect_run(c+5,  PH_SETUP,  1, 16'h00A5, 1'b0);
    expect_run(c+6,  PH_ON,     3, 16'h00A5, 1'b0);
    expect_run(c+9,  PH_DEAD,   1, 16'h00A5, 1'b0);
    expect_run(c+10, PH_RETURN, 1, 16'h00A5, 1'b0);
    expect_run(c+11, PH_IDLE,   2, 16'h0000, 1'b1);
    step(3);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    step(1);
    bus.enable = 1'b0;
    step(8);

    // cell_state changed during DEAD takes effect on the next cycle's latch
    c = cyc;
    bus.ccr0 = 1; bus.ccr1 = 1; bus.ccr2 = 2; bus.ccr3 = 1;
    bus.cell_state = 16'h00FF;
    bus.enable = 1'b1;
    expect_run(c+1,  PH_SETUP,  1, 16'h00FF, 1'b0);
    expect_run(c+2,  PH_ON,     1, 16'h00FF, 1'b0);
    expect_run(c+3,  PH_DEAD,   2, 16'h00FF, 1'b0);
    expect_run(c+5,  PH_RETURN, 1, 16'h00FF, 1'b0);
    expect_run(c+6,  PH_SETUP,  1, 16'hFF00, 1'b1);
    expect_run(c+7,  PH_ON,     1, 16'hFF00, 1'b0);
    expect_run(c+8,  PH_DEAD,   2, 16'hFF00, 1'b0);
    expect_run(c+10, PH_RETURN, 1, 16'hFF00, 1'b0);
    expect_run(c+11, PH_IDLE,   2, 16'h0000, 1'b1);
    step(3);
    bus.cell_state = 16'hFF00;
    step(4);
    bus.enable = 1'b0;
    step(6);

    // reset asserted mid-RETURN
    c = cyc;
    bus.ccr0 = 1; bus.ccr1 = 1; bus.ccr2 = 1; bus.ccr3 = 3;
    bus.cell_state = 16'h0003;
    bus.enable = 1'b1;
    expect_run(c+1, PH_SETUP,  1, 16'h0003, 1'b0);
    expect_run(c+2, PH_ON,     1, 16'h0003, 1'b0);
    expect_run(c+3, PH_DEAD,   1, 16'h0003, 1'b0);
    expect_run(c+4, PH_RETURN, 1, 16'h0003, 1'b0);
    expect_run(c+5, PH_IDLE,   2, 16'h0000, 1'b0);
    step(4);
    reset = 1'b1;
    bus.enable = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
